ad9911_spi_writer: RTL and testbench

- Serial-port write engine for the AD9911 DDS, directly downstream of the register-init/frequency-update controller.
- Accepts one register write per TR rising edge (ADDR, DATA), serialises instruction byte + data bytes MSB-first on the AD9911 3-wire SPI, optionally pulses IO_UPDATE, then raises OVER.
- Write-only; no readback.

---
 rtl/ad9911_spi_writer.sv | 194 +++++++++++++++++++
 tb/tb_ad9911_spi_writer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9911_spi_writer.sv
// AD9911 serial-port write engine.
// Takes one register write per sampled rising edge of TR, sends the
// instruction byte followed by the register's data bytes MSB-first on the
// 3-wire SPI, optionally pulses IO_UPDATE, then raises OVER again.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-high reset
//   TR         transfer request, rising edge starts one write
//   ADDR[7:0]  register address (0x00..0x18 legal)
//   DATA[31:0] register value, right-justified
//   OVER       1 = idle / last write complete, 0 = busy
//   ADDR_ERR   one-cycle pulse when ADDR is rejected
//   SCLK       serial clock, idle low
//   SDIO       serial data, changes while SCLK low
//   CS_N       chip select, active low
//   IO_UPDATE  register-commit pulse, active high
module ad9911_spi_writer #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned UPD_WIDTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TR,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DATA,
  output logic        OVER,
  output logic        ADDR_ERR,
  output logic        SCLK,
  output logic        SDIO,
  output logic        CS_N,
  output logic        IO_UPDATE
);

  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] CSS_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] UPD_LAST = TW'(UPD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_UPDATE,
    S_DONE,
    S_ERR
  } state_t;

  // Zero-length setup/hold/update phases are skipped entirely.
  localparam state_t AFTER_HOLD  = (UPD_WIDTH > 0) ? S_UPDATE : S_DONE;
  localparam state_t AFTER_SHIFT = (CS_SETUP > 0) ? S_HOLD : AFTER_HOLD;
  localparam state_t FIRST_STATE = (CS_SETUP > 0) ? S_SETUP : S_SHIFT;

  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [5:0]    bits, bits_n;
  logic [39:0]   sh, sh_n;
  logic          sclk_n, cs_n_n, over_n, err_n, upd_n;
  logic          tr_q;
  logic          start;
  logic [7:0]    instr;
  logic [5:0]    frame_bits;
  logic [39:0]   frame_word;

  assign start = TR & ~tr_q;
  assign instr = {3'b000, ADDR[4:0]};
  // Frame is left-aligned with zero padding, so once the last bit has been
  // shifted out SDIO naturally returns to 0.
  assign SDIO  = sh[39];

  always_comb begin
    frame_bits = 6'd40;
    frame_word = {instr, DATA};
    case (ADDR[4:0])
      5'h00: begin
        frame_bits = 6'd16;
        frame_word = {instr, DATA[7:0], 24'h0};
      end
      5'h02, 5'h05, 5'h07: begin
        frame_bits = 6'd24;
        frame_word = {instr, DATA[15:0], 16'h0};
      end
      5'h01, 5'h03, 5'h06: begin
        frame_bits = 6'd32;
        frame_word = {instr, DATA[23:0], 8'h0};
      end
      default: begin
        frame_bits = 6'd40;
        frame_word = {instr, DATA};
      end
    endcase
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    bits_n  = bits;
    sh_n    = sh;
    sclk_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (ADDR > 8'h18) begin
            state_n = S_ERR;
          end else begin
            state_n = FIRST_STATE;
            sh_n    = frame_word;
            bits_n  = frame_bits;
            tmr_n   = '0;
          end
        end
      end
      S_SETUP: begin
        if (tmr == CSS_LAST) begin
          state_n = S_SHIFT;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      S_SHIFT: begin
        sclk_n = SCLK;
        if (tmr == DIV_LAST) begin
          tmr_n = '0;
          if (!SCLK) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            sh_n   = {sh[38:0], 1'b0};
            bits_n = bits - 1'b1;
            if (bits == 6'd1) state_n = AFTER_SHIFT;
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr == CSS_LAST) begin
          state_n = AFTER_HOLD;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      S_UPDATE: begin
        if (tmr == UPD_LAST) begin
          state_n = S_DONE;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so the pins
    // come straight from flops and cannot glitch.
    cs_n_n = !(state_n == S_SETUP || state_n == S_SHIFT || state_n == S_HOLD);
    over_n = (state_n == S_IDLE) || (state_n == S_DONE);
    err_n  = (state_n == S_ERR);
    upd_n  = (state_n == S_UPDATE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      tmr       <= '0;
      bits      <= '0;
      sh        <= '0;
      tr_q      <= 1'b1;
      SCLK      <= 1'b0;
      CS_N      <= 1'b1;
      OVER      <= 1'b1;
      ADDR_ERR  <= 1'b0;
      IO_UPDATE <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      bits      <= bits_n;
      sh        <= sh_n;
      tr_q      <= TR;
      SCLK      <= sclk_n;
      CS_N      <= cs_n_n;
      OVER      <= over_n;
      ADDR_ERR  <= err_n;
      IO_UPDATE <= upd_n;
    end
  end

endmodule

// File: tb/tb_ad9911_spi_writer.sv
// Self-checking bench for ad9911_spi_writer: a cycle-offset model of each
// write is compared against every DUT output on every falling clock edge,
// while directed cases pin the model with hand-computed frame contents.
module tb_ad9911_spi_writer;

  localparam int D = 2;
  localparam int S = 2;
  localparam int U = 4;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  logic        TR    = 1'b1;
  logic [7:0]  ADDR  = '0;
  logic [31:0] DATA  = '0;
  logic        OVER, ADDR_ERR, SCLK, SDIO, CS_N, IO_UPDATE;

  int checks = 0;
  int errors = 0;

  ad9911_spi_writer #(.CLK_DIV(D), .CS_SETUP(S), .UPD_WIDTH(U)) dut (
    .CLK(CLK), .RESET(RESET), .TR(TR), .ADDR(ADDR), .DATA(DATA),
    .OVER(OVER), .ADDR_ERR(ADDR_ERR), .SCLK(SCLK), .SDIO(SDIO),
    .CS_N(CS_N), .IO_UPDATE(IO_UPDATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t counts clock edges since the edge that accepted the write.
  bit          m_active = 1'b0;
  bit          m_err    = 1'b0;
  int          m_t      = 0;
  int          m_len    = 0;
  int          m_nbits  = 16;
  logic [63:0] m_word   = '0;
  logic        tr_prev  = 1'b1;

  function automatic int nbytes_of(input logic [4:0] a);
    case (a)
      5'h00:               return 1;
      5'h01, 5'h03, 5'h06: return 3;
      5'h02, 5'h05, 5'h07: return 2;
      default:             return 4;
    endcase
  endfunction

  initial begin
    int nb;
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        m_active = 1'b0;
        tr_prev  = 1'b1;
      end else begin
        if (m_active) begin
          m_t++;
          if (m_t > m_len) m_active = 1'b0;
        end else if (TR && !tr_prev) begin
          m_active = 1'b1;
          m_t      = 0;
          if (ADDR > 8'h18) begin
            m_err = 1'b1;
            m_len = 0;
          end else begin
            m_err   = 1'b0;
            nb      = nbytes_of(ADDR[4:0]);
            m_nbits = 8 + 8 * nb;
            m_word  = (64'(ADDR[4:0]) << (8 * nb)) | (64'(DATA) & ((64'd1 << (8 * nb)) - 64'd1));
            m_len   = 2 * S + m_nbits * 2 * D + U;
          end
        end
        tr_prev = TR;
      end
    end
  end

  // ---------------- compare + bus monitors ----------------
  int          frames = 0, upd_pulses = 0, err_pulses = 0, over_rises = 0;
  int          last_rises = 0, last_cs = 0, last_upd = 0;
  logic [63:0] last_val = '0;
  int          mon_rises = 0, mon_cs = 0, upd_run = 0;
  logic [63:0] mon_val = '0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0, upd_prev = 1'b0, over_prev = 1'b1;

  initial begin
    logic e_over, e_err, e_cs, e_sclk, e_sdio, e_upd;
    int u;
    forever begin
      @(negedge CLK);
      e_over = 1'b1; e_err = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_sdio = 1'b0; e_upd = 1'b0;
      if (m_active) begin
        e_over = 1'b0;
        if (m_err) begin
          e_err = 1'b1;
        end else if (m_t < S) begin
          e_cs   = 1'b0;
          e_sdio = m_word[m_nbits - 1];
        end else if (m_t < S + m_nbits * 2 * D) begin
          u      = m_t - S;
          e_cs   = 1'b0;
          e_sclk = (u % (2 * D)) >= D;
          e_sdio = m_word[m_nbits - 1 - u / (2 * D)];
        end else if (m_t < 2 * S + m_nbits * 2 * D) begin
          e_cs = 1'b0;
        end else if (m_t < m_len) begin
          e_upd = 1'b1;
        end else begin
          e_over = 1'b1;
        end
      end
      chk1("OVER", OVER, e_over);
      chk1("ADDR_ERR", ADDR_ERR, e_err);
      chk1("CS_N", CS_N, e_cs);
      chk1("SCLK", SCLK, e_sclk);
      chk1("SDIO", SDIO, e_sdio);
      chk1("IO_UPDATE", IO_UPDATE, e_upd);

      if (RESET) begin
        cs_prev = 1'b1; sclk_prev = 1'b0; upd_prev = 1'b0; over_prev = 1'b1;
        mon_rises = 0; mon_val = '0; mon_cs = 0; upd_run = 0;
      end else begin
        if (!CS_N && cs_prev) begin
          mon_rises = 0; mon_val = '0; mon_cs = 0;
        end
        if (!CS_N) mon_cs++;
        if (SCLK && !sclk_prev) begin
          mon_rises++;
          mon_val = {mon_val[62:0], SDIO};
        end
        if (CS_N && !cs_prev) begin
          frames++;
          last_rises = mon_rises; last_val = mon_val; last_cs = mon_cs;
        end
        if (IO_UPDATE) upd_run++;
        if (!IO_UPDATE && upd_prev) begin
          upd_pulses++;
          last_upd = upd_run;
          upd_run  = 0;
        end
        if (ADDR_ERR) err_pulses++;
        if (OVER && !over_prev) over_rises++;
        cs_prev = CS_N; sclk_prev = SCLK; upd_prev = IO_UPDATE; over_prev = OVER;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (OVER !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: OVER still %b after %0d cycles", OVER, n);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic issue(input logic [7:0] a, input logic [31:0] d, input int hold);
    @(negedge CLK);
    chk1("pre_over", OVER, 1'b1);
    ADDR = a;
    DATA = d;
    TR   = 1'b1;
    @(negedge CLK);
    chk1("over_drop", OVER, 1'b0);
    repeat (hold - 1) @(negedge CLK);
    TR = 1'b0;
    wait_idle();
  endtask

  initial begin
    int f0, p0, o0, e0;
    logic [7:0] a;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;                        // TR still high: must not start
    repeat (6) @(negedge CLK);
    chk1("rst_over", OVER, 1'b1);
    chk1("rst_csn", CS_N, 1'b1);
    chk1("rst_sclk", SCLK, 1'b0);
    chkn("rst_frames", 64'(frames), 64'd0);
    TR = 1'b0;
    repeat (2) @(negedge CLK);

    issue(8'h04, 32'h1234_5678, 2);
    chkn("a04_rises", 64'(last_rises), 64'd40);
    chkn("a04_bits", last_val, 64'h04_1234_5678);
    chkn("a04_cs_low", 64'(last_cs), 64'd164);
    chkn("a04_upd_w", 64'(last_upd), 64'd4);
    chkn("a04_frames", 64'(frames), 64'd1);

    issue(8'h00, 32'hFFFF_FF20, 1);
    chkn("a00_rises", 64'(last_rises), 64'd16);
    chkn("a00_bits", last_val, 64'h0020);

    f0 = frames; p0 = upd_pulses;
    issue(8'h02, 32'hA5C3_9E11, 1);
    chkn("a02_rises", 64'(last_rises), 64'd24);
    chkn("a02_bits", last_val, 64'h02_9E11);
    issue(8'h06, 32'h0BAD_CAFE, 1);
    chkn("a06_rises", 64'(last_rises), 64'd32);
    chkn("a06_bits", last_val, 64'h06_AD_CAFE);
    chkn("b2b_frames", 64'(frames - f0), 64'd2);
    chkn("b2b_upd", 64'(upd_pulses - p0), 64'd2);

    // second TR edge in the middle of SHIFT must be ignored
    f0 = frames; o0 = over_rises;
    @(negedge CLK); ADDR = 8'h05; DATA = 32'h0000_BEEF; TR = 1'b1;
    @(negedge CLK); TR = 1'b0;
    repeat (20) @(negedge CLK);
    ADDR = 8'h04; DATA = 32'hFFFF_FFFF; TR = 1'b1;
    @(negedge CLK); TR = 1'b0;
    wait_idle();
    chkn("busy_rises", 64'(last_rises), 64'd24);
    chkn("busy_bits", last_val, 64'h05_BEEF);
    chkn("busy_frames", 64'(frames - f0), 64'd1);
    chkn("busy_over_rises", 64'(over_rises - o0), 64'd1);

    // illegal address
    e0 = err_pulses; f0 = frames;
    @(negedge CLK); ADDR = 8'h1F; DATA = 32'h1111_2222; TR = 1'b1;
    @(negedge CLK);
    chk1("err_over", OVER, 1'b0);
    chk1("err_pulse", ADDR_ERR, 1'b1);
    chk1("err_csn", CS_N, 1'b1);
    @(negedge CLK);
    chk1("err_over_back", OVER, 1'b1);
    chk1("err_pulse_end", ADDR_ERR, 1'b0);
    TR = 1'b0;
    repeat (3) @(negedge CLK);
    chkn("err_frames", 64'(frames), 64'(f0));
    chkn("err_count", 64'(err_pulses - e0), 64'd1);

    // asynchronous reset in the middle of SHIFT
    f0 = frames;
    @(negedge CLK); ADDR = 8'h04; DATA = $urandom; TR = 1'b1;
    @(negedge CLK); TR = 1'b0;
    repeat (30) @(negedge CLK);
    chk1("mid_csn_low", CS_N, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk1("mid_rst_csn", CS_N, 1'b1);
    chk1("mid_rst_sclk", SCLK, 1'b0);
    chk1("mid_rst_over", OVER, 1'b1);
    chk1("mid_rst_sdio", SDIO, 1'b0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chkn("mid_rst_frames", 64'(frames), 64'(f0));

    // randomized writes with occasional stray TR edges while busy
    for (int i = 0; i < 50; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'h19, 8'hFF))
                                      : 8'($urandom_range(0, 8'h18));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      @(negedge CLK); ADDR = a; DATA = $urandom; TR = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge CLK);
      TR = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 60)) @(negedge CLK);
        ADDR = 8'($urandom_range(0, 31)); DATA = $urandom; TR = 1'b1;
        @(negedge CLK); TR = 1'b0;
      end
      wait_idle();
    end

    // free-running TR toggling, no handshake
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 15) == 0) TR = ~TR;
      if ($urandom_range(0, 3) == 0) begin
        ADDR = 8'($urandom_range(0, 31));
        DATA = $urandom;
      end
    end
    TR = 1'b0;
    wait_idle();
    repeat (4) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
